// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encodings and
// the constants used to step and redirect the program counter.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ERROR = 2'd2
    } fetch_state_e;

    localparam int unsigned PC_INCR  = 4;
    localparam int unsigned BR_SHIFT = 2;
    localparam int unsigned OPC_MSB  = 31;
    localparam int unsigned OPC_LSB  = 21;
    localparam int unsigned OPC_W    = OPC_MSB - OPC_LSB + 1;

endpackage

// File: rtl/instr_fetch_next_pc_sel.sv
// Combinational next-PC selection: sequential step, or PC-relative word-offset
// branch target when taken.
module next_pc_sel
    import instr_fetch_pkg::*;
#(
    parameter int PC_W = 64
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic [PC_W-1:0] branch_offset_i,
    input  logic            branch_i,
    input  logic            uncond_branch_i,
    input  logic            zero_i,
    output logic [PC_W-1:0] next_pc_o
);

    logic [PC_W-1:0] target;
    logic [PC_W-1:0] seq_pc;

    assign target = pc_i + (branch_offset_i << BR_SHIFT);
    assign seq_pc = pc_i + PC_W'(PC_INCR);

    // Unconditional branch is tested first so an undriven branch flag for B
    // never reaches the PC.
    always_comb begin
        next_pc_o = seq_pc;
        if (uncond_branch_i) begin
            next_pc_o = target;
        end else if (branch_i && zero_i) begin
            next_pc_o = target;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, fetches one instruction per retirement over a
// req/ack memory port, and flags a sticky error when memory stops answering.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               CLK,
    input  logic               resetl,
    input  logic [PC_W-1:0]    startpc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [OPC_W-1:0]   opcode,
    output logic [PC_W-1:0]    pc,
    output logic               instr_valid,
    input  logic               stall,
    input  logic               branch,
    input  logic               uncond_branch,
    input  logic               zero,
    input  logic [PC_W-1:0]    branch_offset,
    output logic               fetch_err,
    output logic [31:0]        retired
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_e       state_q;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    next_pc_d;
    logic [INSTR_W-1:0] instr_q;
    logic               vld_q;
    logic               req_q;
    logic               err_q;
    logic [31:0]        retired_q;
    logic [CNT_W-1:0]   wait_q;

    next_pc_sel #(
        .PC_W(PC_W)
    ) u_next_pc_sel (
        .pc_i            (pc_q),
        .branch_offset_i (branch_offset),
        .branch_i        (branch),
        .uncond_branch_i (uncond_branch),
        .zero_i          (zero),
        .next_pc_o       (next_pc_d)
    );

    // The request is a registered output that is set on every entry to FETCH,
    // so it is already high in the first cycle after reset.
    always_ff @(posedge CLK) begin
        if (!resetl) begin
            state_q   <= ST_FETCH;
            pc_q      <= startpc & ~PC_W'(3);
            instr_q   <= '0;
            vld_q     <= 1'b0;
            req_q     <= 1'b1;
            err_q     <= 1'b0;
            retired_q <= '0;
            wait_q    <= '0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        vld_q   <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= ST_ISSUE;
                    end else if (wait_q == WAIT_LAST) begin
                        err_q   <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= ST_ERROR;
                    end else begin
                        wait_q <= wait_q + CNT_W'(1);
                    end
                end
                ST_ISSUE: begin
                    if (!stall) begin
                        pc_q      <= next_pc_d;
                        retired_q <= retired_q + 32'd1;
                        vld_q     <= 1'b0;
                        wait_q    <= '0;
                        req_q     <= 1'b1;
                        state_q   <= ST_FETCH;
                    end
                end
                ST_ERROR: begin
                    req_q <= 1'b0;
                    vld_q <= 1'b0;
                end
                default: begin
                    err_q   <= 1'b1;
                    req_q   <= 1'b0;
                    vld_q   <= 1'b0;
                    state_q <= ST_ERROR;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[OPC_MSB:OPC_LSB];
    assign pc          = pc_q;
    assign instr_valid = vld_q;
    assign fetch_err   = err_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected fetch addresses and instruction
// words are queued as stimulus is driven and popped as the DUT presents them.
module tb_instr_fetch;

    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;
    localparam int TIMEOUT = 4;

    logic               CLK = 1'b0;
    logic               resetl;
    logic [PC_W-1:0]    startpc;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr;
    logic [10:0]        opcode;
    logic [PC_W-1:0]    pc;
    logic               instr_valid;
    logic               stall;
    logic               branch;
    logic               uncond_branch;
    logic               zero;
    logic [PC_W-1:0]    branch_offset;
    logic               fetch_err;
    logic [31:0]        retired;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [63:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];
    logic [63:0] model_pc;
    logic [31:0] model_ret;

    instr_fetch #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .resetl(resetl), .startpc(startpc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode), .pc(pc),
        .instr_valid(instr_valid), .stall(stall), .branch(branch),
        .uncond_branch(uncond_branch), .zero(zero),
        .branch_offset(branch_offset), .fetch_err(fetch_err), .retired(retired)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input logic [63:0] sp);
        startpc = sp; resetl = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        stall = 1'b0; branch = 1'b0; uncond_branch = 1'b0; zero = 1'b0;
        branch_offset = '0;
        tick();
        resetl = 1'b1;
        exp_addr_q.delete();
        exp_instr_q.delete();
        model_pc  = sp & ~64'd3;
        model_ret = 0;
        exp_addr_q.push_back(model_pc);
        check_eq("rst_req", imem_req, 1);
        check_eq("rst_vld", instr_valid, 0);
        check_eq("rst_instr", instr, 0);
        check_eq("rst_err", fetch_err, 0);
        check_eq("rst_retired", retired, 0);
    endtask

    task automatic fetch(input int lat, input logic [31:0] data);
        int n = 0;
        logic [31:0] e;
        while (imem_req !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (imem_req !== 1'b1) begin
            check_eq("req_wait", imem_req, 1);
            return;
        end
        if (exp_addr_q.size() == 0) check_eq("addr_q_empty", imem_addr, 64'hDEAD);
        else check_eq("fetch_addr", imem_addr, exp_addr_q.pop_front());
        repeat (lat) tick();
        imem_ack = 1'b1;
        imem_rdata = data;
        exp_instr_q.push_back(data);
        tick();
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        e = exp_instr_q.pop_front();
        check_eq("issue_vld", instr_valid, 1);
        check_eq("issue_req", imem_req, 0);
        check_eq("issue_instr", instr, e);
        check_eq("issue_opcode", opcode, e[31:21]);
        check_eq("issue_pc", pc, model_pc);
    endtask

    task automatic retire(input logic br, input logic ub, input logic z, input logic [63:0] off);
        branch = br; uncond_branch = ub; zero = z; branch_offset = off; stall = 1'b0;
        if (ub === 1'b1) model_pc = model_pc + off * 64'd4;
        else if (br === 1'b1 && z === 1'b1) model_pc = model_pc + off * 64'd4;
        else model_pc = model_pc + 64'd4;
        model_ret = model_ret + 1;
        exp_addr_q.push_back(model_pc);
        tick();
        branch = 1'b0; uncond_branch = 1'b0; zero = 1'b0; branch_offset = '0;
        check_eq("ret_vld", instr_valid, 0);
        check_eq("ret_req", imem_req, 1);
        check_eq("ret_count", retired, model_ret);
    endtask

    initial begin
        int c0;
        logic [31:0] held;
        resetl = 1'b0;

        // Sequential fetch, single-cycle ack, 2 cycles per instruction
        do_reset(64'h1002);
        c0 = cyc;
        fetch(0, 32'h8B02_0020);
        retire(0, 0, 0, 0);
        fetch(0, 32'hCB01_0041);
        retire(0, 0, 0, 0);
        fetch(0, 32'hF840_0062);
        retire(0, 0, 0, 0);
        check_eq("t1_cycles", 64'(cyc - c0), 6);
        check_eq("t1_retired", retired, 3);
        fetch(2, 32'h1234_5678);

        // Conditional branch taken with negative offset, then not taken
        do_reset(64'h100);
        fetch(1, 32'hB400_0040);
        retire(1, 0, 1, -64'sd2);
        fetch(0, 32'h0);
        do_reset(64'h100);
        fetch(0, 32'hB400_0041);
        retire(1, 0, 0, -64'sd2);
        fetch(3, 32'hFFFF_FFFF);

        // Unconditional branch with undriven branch flag
        do_reset(64'h40);
        fetch(0, 32'h1400_0010);
        retire(1'bx, 1, 0, 64'h10);
        check_eq("t3_no_x", 64'($isunknown(imem_addr)), 0);
        fetch(0, 32'hAAAA_5555);

        // Stall for 5 cycles with spurious acks, then retire
        do_reset(64'h200);
        fetch(0, 32'hDEAD_BEEF);
        held = 32'hDEAD_BEEF;
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            imem_ack = (i % 2) == 0;
            imem_rdata = $urandom;
            branch = 1'b1; zero = 1'b1; uncond_branch = 1'b1; branch_offset = $urandom;
            tick();
            check_eq("stall_vld", instr_valid, 1);
            check_eq("stall_req", imem_req, 0);
            check_eq("stall_instr", instr, held);
            check_eq("stall_pc", pc, 64'h200);
            check_eq("stall_retired", retired, 0);
        end
        imem_ack = 1'b0;
        retire(0, 0, 0, 0);
        fetch(0, 32'h0BAD_F00D);

        // Timeout to sticky error, ignored acks, recovery by reset
        do_reset(64'h2000);
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        check_eq("to_err_early", fetch_err, 0);
        check_eq("to_req_early", imem_req, 1);
        tick();
        check_eq("to_err", fetch_err, 1);
        check_eq("to_req_off", imem_req, 0);
        imem_ack = 1'b1;
        imem_rdata = 32'h5555_AAAA;
        repeat (3) tick();
        imem_ack = 1'b0;
        check_eq("err_sticky", fetch_err, 1);
        check_eq("err_vld", instr_valid, 0);
        check_eq("err_req", imem_req, 0);
        do_reset(64'h3004);
        fetch(0, 32'h1111_2222);

        // PC wraparound, then reset in mid-fetch and mid-stall
        do_reset(64'hFFFF_FFFF_FFFF_FFFC);
        fetch(0, 32'h7777_0000);
        retire(0, 0, 0, 0);
        fetch(0, 32'h7777_0001);
        retire(0, 0, 0, 0);
        tick();
        do_reset(64'h500);
        check_eq("midfetch_addr", imem_addr, 64'h500);
        fetch(0, 32'h3333_4444);
        stall = 1'b1;
        tick();
        do_reset(64'h600);
        fetch(1, 32'h4444_5555);
        retire(0, 0, 0, 0);
        check_eq("midstall_retired", retired, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
